seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_scan_driver_hex_decode.sv | 12 +
 rtl/seg_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg_scan_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment constants, hex glyph table, pin polarity helper.
// Segment vectors are {A,B,C,D,E,F,G}, so bit 6 is A and bit 0 is G.
package seg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic pol_bit(
    input logic b,
    input logic active_low
  );
    return b ^ active_low;
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// seg_hex_decode: combinational nibble to {A..G} segment decoder.
// Ports: hex (4-bit digit in), seg (7-bit active-high segments out).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: N-digit multiplexed hex 7-seg driver with LZ blanking.
// Ports: clk, rst, en, load, value, dp_in, lz_en -> seg, dp, dig_en.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 100000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   dig_en
);

  localparam int   PW  = $clog2(SCAN_DIV);
  localparam int   IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int   VW  = 4 * N_DIGITS;
  localparam logic POL = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic [VW-1:0]       sh_val;
  logic [N_DIGITS-1:0] sh_dp;
  logic                tick;

  logic [3:0]          nib;
  logic                nib_dp;
  logic                blank;
  logic                acc;
  logic [N_DIGITS-1:0] zero_up;
  logic [6:0]          dec_seg;

  // cur_* remembers the lit digit so it can be restored after en drops
  logic [6:0]          cur_seg;
  logic                cur_dp;
  logic [N_DIGITS-1:0] cur_dig;
  logic [6:0]          nxt_seg;
  logic                nxt_dp;
  logic [N_DIGITS-1:0] nxt_dig;

  logic [6:0]          seg_q;
  logic                dp_q;
  logic [N_DIGITS-1:0] dig_q;

  assign tick    = (presc == PW'(SCAN_DIV - 1));
  assign idx_nxt = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);

  // zero_up[i]: nibbles i..top are all zero
  always_comb begin
    acc     = 1'b1;
    zero_up = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      acc        = acc & (sh_val[i*4 +: 4] == 4'h0);
      zero_up[i] = acc;
    end
  end

  always_comb begin
    nib    = '0;
    nib_dp = 1'b0;
    blank  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = sh_val[i*4 +: 4];
        nib_dp = sh_dp[i];
        blank  = lz_en && (i > 0) && zero_up[i];
      end
    end
  end

  seg_hex_decode u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  always_comb begin
    nxt_seg = cur_seg;
    nxt_dp  = cur_dp;
    nxt_dig = cur_dig;
    if (tick) begin
      nxt_seg = blank ? 7'h00 : dec_seg;
      nxt_dp  = nib_dp;
      nxt_dig = N_DIGITS'(1) << idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      idx     <= '0;
      sh_val  <= '0;
      sh_dp   <= '0;
      cur_seg <= '0;
      cur_dp  <= 1'b0;
      cur_dig <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      dig_q   <= '0;
    end else begin
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp_in;
      end
      if (en) begin
        presc   <= tick ? '0 : presc + PW'(1);
        if (tick) idx <= idx_nxt;
        cur_seg <= nxt_seg;
        cur_dp  <= nxt_dp;
        cur_dig <= nxt_dig;
        seg_q   <= nxt_seg;
        dp_q    <= nxt_dp;
        dig_q   <= nxt_dig;
      end else begin
        seg_q <= '0;
        dp_q  <= 1'b0;
        dig_q <= '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 7; i++) seg[i] = pol_bit(seg_q[i], POL);
    dp = pol_bit(dp_q, POL);
    for (int i = 0; i < N_DIGITS; i++) dig_en[i] = pol_bit(dig_q[i], POL);
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for two seg_scan_driver configs.
// A: 4 digits, div 4, active-high. B: 1 digit, div 2, active-low.
module tb_seg_scan_driver;

  localparam logic [6:0] TBL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b0;
  logic        load  = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  dig_a;
  logic [0:0]  dig_b;

  seg_scan_driver #(
    .N_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .value(value), .dp_in(dp_in), .lz_en(lz_en),
    .seg(seg_a), .dp(dp_a), .dig_en(dig_a)
  );

  seg_scan_driver #(
    .N_DIGITS(1), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .value(value[3:0]), .dp_in(dp_in[0:0]), .lz_en(lz_en),
    .seg(seg_b), .dp(dp_b), .dig_en(dig_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ecnt;
    logic [31:0] sv;
    logic [7:0]  sd;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  dig;
    logic        on;
  } ms_t;

  typedef struct {
    logic [6:0] seg_a;
    logic       dp_a;
    logic [3:0] dig_a;
    logic [6:0] seg_b;
    logic       dp_b;
    logic       dig_b;
  } exp_t;

  ms_t  ma, mb;
  exp_t q[$];
  exp_t mx;
  int   checks = 0;
  int   passed = 0;

  function automatic ms_t mreset();
    ms_t s;
    s.ecnt = 0; s.sv = '0; s.sd = '0;
    s.seg = '0; s.dp = 1'b0; s.dig = '0; s.on = 1'b0;
    return s;
  endfunction

  // Digit k is lit after every div-th enabled edge, cycling 0..n-1.
  function automatic ms_t mnext(ms_t s, int n, int div, logic e,
                                logic ld, logic lz,
                                logic [31:0] v, logic [7:0] d);
    ms_t r = s;
    int k;
    logic [31:0] upper;
    r.on = e;
    if (e) begin
      r.ecnt = s.ecnt + 1;
      if (r.ecnt % div == 0) begin
        k     = (r.ecnt / div - 1) % n;
        upper = s.sv >> (4 * k);
        r.dig = 8'(1) << k;
        r.seg = (lz && k > 0 && upper == 0) ? 7'h00 : TBL[upper[3:0]];
        r.dp  = s.sd[k];
      end
    end
    if (ld) begin
      r.sv = v & ((32'h1 << (4 * n)) - 32'h1);
      r.sd = d & ((8'h1 << n) - 8'h1);
    end
    return r;
  endfunction

  function automatic exp_t mk();
    exp_t e;
    e.seg_a = ma.on ? ma.seg : 7'h00;
    e.dp_a  = ma.on & ma.dp;
    e.dig_a = ma.on ? ma.dig[3:0] : 4'h0;
    e.seg_b = ~(mb.on ? mb.seg : 7'h00);
    e.dp_b  = ~(mb.on & mb.dp);
    e.dig_b = ~(mb.on & mb.dig[0]);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic step(logic r, logic e, logic ld, logic lz,
                      logic [15:0] v, logic [3:0] d);
    @(negedge clk);
    rst = r; en = e; load = ld; lz_en = lz; value = v; dp_in = d;
    if (r) begin
      ma = mreset();
      mb = mreset();
    end else begin
      ma = mnext(ma, 4, 4, e, ld, lz, {16'h0, v}, {4'h0, d});
      mb = mnext(mb, 1, 2, e, ld, lz, {16'h0, v}, {4'h0, d});
    end
    q.push_back(mk());
  endtask

  task automatic idle(int n, logic e, logic lz);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, lz, value, dp_in);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_seg_a", seg_a, 7'h00);
    chk("arst_dig_a", dig_a, 4'h0);
    chk("arst_dp_a", dp_a, 1'b0);
    chk("arst_seg_b", seg_b, 7'h7f);
    chk("arst_dig_b", dig_b, 1'b1);
    chk("arst_dp_b", dp_b, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'hbeef, 4'hf);
  endtask

  // Monitor: compare each edge's outputs against the queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mx = q.pop_front();
        chk("seg_a", seg_a, mx.seg_a);
        chk("dp_a", dp_a, mx.dp_a);
        chk("dig_a", dig_a, mx.dig_a);
        chk("seg_b", seg_b, mx.seg_b);
        chk("dp_b", dp_b, mx.dp_b);
        chk("dig_b", dig_b, mx.dig_b);
      end
    end
  end

  initial begin
    logic [15:0] masks [5];
    masks[0] = 16'h0000; masks[1] = 16'h000f; masks[2] = 16'h00ff;
    masks[3] = 16'h0fff; masks[4] = 16'hffff;
    ma = mreset();
    mb = mreset();
    #3;
    chk("rst_seg_a", seg_a, 7'h00);
    chk("rst_dig_a", dig_a, 4'h0);
    chk("rst_seg_b", seg_b, 7'h7f);
    chk("rst_dig_b", dig_b, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h12af, 4'b0100);
    idle(40, 1'b1, 1'b0);

    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0030, 4'b0000);
    idle(20, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'b0000);
    idle(20, 1'b1, 1'b1);

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1111, 4'b0000);
    idle(3, 1'b1, 1'b0);
    for (int i = 0; i < 8 && ((ma.ecnt + 1) % 4) != 0; i++)
      idle(1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h2222, 4'b0000);
    idle(12, 1'b1, 1'b0);

    for (int i = 0; i < 12 && (ma.ecnt % 16) != 9; i++)
      idle(1, 1'b1, 1'b0);
    idle(10, 1'b0, 1'b0);
    idle(12, 1'b1, 1'b0);

    idle(6, 1'b1, 1'b0);
    pulse_rst();
    idle(10, 1'b1, 1'b0);

    for (int n = 0; n < 16; n++) begin
      value = {4{4'(n)}};
      step(1'b0, 1'b1, 1'b1, 1'b0, value, 4'(n));
      idle(3, 1'b1, 1'b0);
    end

    for (int i = 0; i < 600; i++) begin
      step(1'b0,
           ($urandom % 12) != 0,
           ($urandom % 6) == 0,
           1'($urandom),
           16'($urandom) & masks[$urandom % 5],
           4'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
